// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer: mode encoding, per-step strobe
// masks (bit n = step n) and the NTSC step length.
package apu_pkg;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } frame_mode_e;

  localparam int DEFAULT_STEP_CYCLES = 7457;

  localparam logic [4:0] QUARTER_MASK_4STEP = 5'b01111;
  localparam logic [4:0] HALF_MASK_4STEP    = 5'b01010;
  localparam logic [4:0] IRQ_MASK_4STEP     = 5'b01000;

  localparam logic [4:0] QUARTER_MASK_5STEP = 5'b10111;
  localparam logic [4:0] HALF_MASK_5STEP    = 5'b10010;
  localparam logic [4:0] IRQ_MASK_5STEP     = 5'b00000;

  // True when the given step's bit is set in a 5-entry step mask.
  function automatic logic step_hit(input logic [4:0] mask, input logic [2:0] step);
    return |(mask & (5'b00001 << step));
  endfunction

  function automatic logic [2:0] last_step(input frame_mode_e mode);
    return (mode == MODE_5STEP) ? 3'd4 : 3'd3;
  endfunction

endpackage

// File: rtl/apu_frame_divider.sv
// Step prescaler: counts 0..STEP_CYCLES-1 and flags the terminal count so the
// sequencer can advance. A synchronous clear restarts the step from 0.
module apu_frame_divider #(
  parameter int STEP_CYCLES = 7457
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tc_o
);

  localparam int W = $clog2(STEP_CYCLES);
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: turns divider terminal counts into registered
// quarter/half-frame strobes and maintains the frame interrupt flag.
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] reg_4017,
  input  logic       reg_event,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  frame_mode_e mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic [2:0]  step_q, step_d;
  logic        quarter_q, quarter_d;
  logic        half_q, half_d;
  logic        irq_q, irq_d;
  logic        tc;
  logic        unused_reg_bits;

  logic [4:0]  quarter_mask;
  logic [4:0]  half_mask;
  logic [4:0]  irq_mask;

  assign unused_reg_bits = ^reg_4017[5:0];

  apu_frame_divider #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .clear_i (reg_event),
    .tc_o    (tc)
  );

  always_comb begin
    quarter_mask = QUARTER_MASK_4STEP;
    half_mask    = HALF_MASK_4STEP;
    irq_mask     = IRQ_MASK_4STEP;
    if (mode_q == MODE_5STEP) begin
      quarter_mask = QUARTER_MASK_5STEP;
      half_mask    = HALF_MASK_5STEP;
      irq_mask     = IRQ_MASK_5STEP;
    end
  end

  // A $4017 write wins over a coincident terminal count; that step is dropped.
  always_comb begin
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    step_d    = step_q;
    quarter_d = 1'b0;
    half_d    = 1'b0;
    irq_d     = irq_q;
    if (reg_event) begin
      mode_d    = frame_mode_e'(reg_4017[7]);
      inhibit_d = reg_4017[6];
      step_d    = 3'd0;
      quarter_d = reg_4017[7];
      half_d    = reg_4017[7];
      if (reg_4017[6] || irq_ack) begin
        irq_d = 1'b0;
      end
    end else begin
      if (tc) begin
        step_d    = (step_q == last_step(mode_q)) ? 3'd0 : step_q + 3'd1;
        quarter_d = step_hit(quarter_mask, step_q);
        half_d    = step_hit(half_mask, step_q);
      end
      if (tc && step_hit(irq_mask, step_q) && !inhibit_q) begin
        irq_d = 1'b1;
      end else if (irq_ack) begin
        irq_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_4STEP;
      inhibit_q <= 1'b0;
      step_q    <= 3'd0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      step_q    <= step_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
      irq_q     <= irq_d;
    end
  end

  assign enable_240hz = quarter_q;
  assign enable_120hz = half_q;
  assign frame_irq    = irq_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter with STEP_CYCLES=8: directed sequence plus random
// traffic, checked every cycle against an elapsed-cycle reference model.
module tb_apu_frame_counter;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] reg_4017 = 8'h00;
  logic       reg_event = 1'b0;
  logic       irq_ack = 1'b0;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;

  int checks = 0;
  int errors = 0;

  // Expected {frame_irq, enable_120hz, enable_240hz}, one entry per clock edge.
  logic [2:0] exp_q[$];

  // Reference model state: cycles since the last restart, plus latched config.
  bit m_mode;
  bit m_inh;
  bit m_irq;
  int m_elapsed;

  apu_frame_counter #(
    .STEP_CYCLES (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .reg_4017     (reg_4017),
    .reg_event    (reg_event),
    .irq_ack      (irq_ack),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 1'b0;
    m_inh = 1'b0;
    m_irq = 1'b0;
    m_elapsed = 0;
  endtask

  // One clock edge of the reference model: step k finishes every N cycles.
  task automatic model_edge(input bit ev, input logic [7:0] d, input bit ack);
    bit q = 1'b0;
    bit h = 1'b0;
    bit set = 1'b0;
    int k;
    if (ev) begin
      m_mode = d[7];
      m_inh = d[6];
      m_elapsed = 0;
      q = d[7];
      h = d[7];
      if (m_inh || ack) m_irq = 1'b0;
    end else begin
      m_elapsed++;
      if (m_elapsed % N == 0) begin
        k = (m_elapsed / N - 1) % (m_mode ? 5 : 4);
        if (!m_mode) begin
          q = 1'b1;
          h = (k == 1) || (k == 3);
          set = (k == 3) && !m_inh;
        end else begin
          q = (k != 3);
          h = (k == 1) || (k == 4);
        end
      end
      if (set) m_irq = 1'b1;
      else if (ack) m_irq = 1'b0;
    end
    exp_q.push_back({m_irq, h, q});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string tag);
    logic [2:0] exp_v;
    logic [2:0] act_v;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, {frame_irq, enable_120hz, enable_240hz});
      return;
    end
    exp_v = exp_q.pop_front();
    act_v = {frame_irq, enable_120hz, enable_240hz};
    checks++;
    assert (act_v === exp_v) else begin
      errors++;
      $error("FAIL %s: {irq,120,240} observed %b expected %b (elapsed %0d)", tag, act_v, exp_v, m_elapsed);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, take the posedge, check at the next negedge.
  task automatic drive_cycle(input bit ev, input logic [7:0] d, input bit ack, input string tag);
    reg_event = ev;
    reg_4017 = d;
    irq_ack = ack;
    @(posedge clk);
    model_edge(ev, d, ack);
    @(negedge clk);
    reg_event = 1'b0;
    irq_ack = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, tag);
  endtask

  task automatic write_4017(input logic [7:0] d, input string tag);
    drive_cycle(1'b1, d, 1'b0, tag);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    exp_q.delete();
    checks++;
    assert ({frame_irq, enable_120hz, enable_240hz} === 3'b000) else begin
      errors++;
      $error("FAIL %s: outputs in reset observed %b expected 000", tag,
             {frame_irq, enable_120hz, enable_240hz});
    end
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    apply_reset("reset_state");

    idle(40, "idle_4step");
    drive_cycle(1'b0, 8'h00, 1'b1, "irq_ack");
    idle(34, "irq_reset_by_step3");

    write_4017(8'h80, "mode5_immediate");
    idle(45, "mode5_run");

    write_4017(8'h00, "mode4_restart");
    idle(33, "mode4_to_irq");
    write_4017(8'h40, "inhibit_clear");
    idle(40, "inhibited_run");

    write_4017(8'h00, "pre_tc_write");
    idle(N - 1, "run_to_tc");
    write_4017(8'h00, "write_at_tc");
    idle(N + 2, "after_tc_write");

    write_4017(8'h80, "mode5_at_tc_setup");
    idle(N - 1, "mode5_run_to_tc");
    write_4017(8'h80, "mode5_write_at_tc");
    idle(N + 2, "mode5_after_tc");

    for (int r = 0; r < 6; r++) begin
      idle($urandom_range(1, N - 1), "rapid_gap");
      write_4017(8'h00, "rapid_write");
    end
    idle(2 * N, "after_rapid");

    // Ack coinciding with the step-3 IRQ set: the set must win.
    write_4017(8'h00, "ack_race_setup");
    idle(4 * N - 1, "ack_race_run");
    drive_cycle(1'b0, 8'h00, 1'b1, "ack_vs_set");
    idle(3, "ack_race_after");

    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 39) == 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 9) == 0, "random");
    end

    write_4017(8'h00, "midreset_setup");
    idle(4 * N + 3, "midreset_run");
    #2 reset = 1'b1;
    #1;
    checks++;
    assert ({frame_irq, enable_120hz, enable_240hz} === 3'b000) else begin
      errors++;
      $error("FAIL async_reset: outputs observed %b expected 000",
             {frame_irq, enable_120hz, enable_240hz});
    end
    @(negedge clk);
    apply_reset("midreset_hold");
    idle(2 * N + 2, "after_midreset");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
